// File: rtl/vxe_cu_vpu_cmd_arb.sv
// vxe_cu_vpu_cmd_arb
// Round-robin arbiter with burst locking that shares one VPU command bus
// among NREQ sel/ack command masters.
//
// Optional feature macro: VXE_CU_VPU_ARB_PRIO_EN
//   defined   : requester 0 has absolute priority in every pick and is never
//               rotated away by the burst limit.
//   undefined : pure round-robin.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   i_req_sel[NREQ]   per-requester command select
//   i_req_op/th/pl    per-requester opcode (5b), thread mask (3b), payload (48b)
//   o_req_ack[NREQ]   bus ack routed to the grantee only
//   o_vpu_cmd_sel     VPU bus select
//   i_vpu_cmd_ack     VPU bus ack
//   o_vpu_cmd_op/th/pl muxed command fields (zero when idle)
//   o_grant[NREQ]     one-hot grant, zero when idle
//   o_busy            GRANT state or any request pending
//
// State   | meaning
// IDLE    | no grantee; wait for any sel
// GRANT   | gidx owns the bus; bcnt counts acks in the current burst

module vxe_cu_vpu_cmd_arb #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_sel,
    input  logic [5*NREQ-1:0]    i_req_op,
    input  logic [3*NREQ-1:0]    i_req_th,
    input  logic [48*NREQ-1:0]   i_req_pl,
    output logic [NREQ-1:0]      o_req_ack,
    output logic                 o_vpu_cmd_sel,
    input  logic                 i_vpu_cmd_ack,
    output logic [4:0]           o_vpu_cmd_op,
    output logic [2:0]           o_vpu_cmd_th,
    output logic [47:0]          o_vpu_cmd_pl,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gidx_q, gidx_d;
    logic [GW-1:0]   rrp_q, rrp_d;
    logic [7:0]      bcnt_q, bcnt_d;

    logic [NREQ-1:0] gmask;
    logic [NREQ-1:0] others;
    logic            gsel;
    logic            bus_sel;
    logic            bus_ack;
    logic            at_limit;
    logic            rotate_ok;

    function automatic logic [GW-1:0] inc_idx(input logic [GW-1:0] i);
        if (int'(i) == NREQ - 1)
            return '0;
        else
            return i + 1'b1;
    endfunction

    // Scan downward so the lowest offset from start wins.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [GW-1:0]   start);
        logic [GW-1:0] res;
        int            idx;
        res = start;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = (int'(start) + off) % NREQ;
            if (req[idx])
                res = GW'(idx);
        end
`ifdef VXE_CU_VPU_ARB_PRIO_EN
        if (req[0])
            res = '0;
`endif
        return res;
    endfunction

    always_comb begin
        gmask         = '0;
        gmask[gidx_q] = 1'b1;
        others        = i_req_sel & ~gmask;
        gsel          = i_req_sel[gidx_q];
        bus_sel       = (state_q == GRANT) && gsel;
        bus_ack       = bus_sel && i_vpu_cmd_ack;
        at_limit      = ({1'b0, bcnt_q} + 9'd1) == 9'(MAX_BURST);
`ifdef VXE_CU_VPU_ARB_PRIO_EN
        rotate_ok     = (gidx_q != '0);
`else
        rotate_ok     = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        bcnt_d  = bcnt_q;
        rrp_d   = rrp_q;
        case (state_q)
            IDLE: begin
                if (|i_req_sel) begin
                    state_d = GRANT;
                    gidx_d  = rr_pick(i_req_sel, rrp_q);
                    bcnt_d  = '0;
                end
            end
            GRANT: begin
                if (!gsel) begin
                    rrp_d  = inc_idx(gidx_q);
                    bcnt_d = '0;
                    if (|others)
                        gidx_d = rr_pick(others, inc_idx(gidx_q));
                    else
                        state_d = IDLE;
                end else if (bus_ack && at_limit && rotate_ok && (|others)) begin
                    // The final ack consumed the old grantee's command, so
                    // switching now loses nothing and adds no bubble.
                    rrp_d  = inc_idx(gidx_q);
                    gidx_d = rr_pick(others, inc_idx(gidx_q));
                    bcnt_d = '0;
                end else if (bus_ack) begin
                    if ({1'b0, bcnt_q} < 9'(MAX_BURST))
                        bcnt_d = bcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            bcnt_q  <= '0;
            rrp_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            bcnt_q  <= bcnt_d;
            rrp_q   <= rrp_d;
        end
    end

    always_comb begin
        o_vpu_cmd_sel = bus_sel;
        o_req_ack     = bus_ack ? gmask : '0;
        o_grant       = (state_q == GRANT) ? gmask : '0;
        o_busy        = (state_q == GRANT) || (|i_req_sel);
        o_vpu_cmd_op  = '0;
        o_vpu_cmd_th  = '0;
        o_vpu_cmd_pl  = '0;
        if (state_q == GRANT) begin
            o_vpu_cmd_op = i_req_op[int'(gidx_q) * 5 +: 5];
            o_vpu_cmd_th = i_req_th[int'(gidx_q) * 3 +: 3];
            o_vpu_cmd_pl = i_req_pl[int'(gidx_q) * 48 +: 48];
        end
    end

endmodule

// File: doc/vxe_cu_vpu_cmd_arb.md
Name: vxe_cu_vpu_cmd_arb

Overview:
- Round-robin arbiter that shares one VPU command bus among NREQ VPU command-bus masters, typically forwarding units for different command sources.
- Each requester uses the standard sel/ack command protocol. While sel is high, op/th/pl are valid. Each ack consumes the current command. The requester either presents the next command or drops sel in the following cycle.
- Grants use burst locking with a burst limit. The arbiter sits between the forwarding units and the VPU command bus.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAX_BURST, 8, maximum commands acked to one grantee before rotation when another requester is pending (1..255).

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- i_req_sel  input  NREQ  per-requester command select.
- i_req_op  input  5*NREQ  requester k opcode at bits [5k+4:5k].
- i_req_th  input  3*NREQ  requester k thread mask at bits [3k+2:3k].
- i_req_pl  input  48*NREQ  requester k payload at bits [48k+47:48k].
- o_req_ack  output  NREQ  per-requester ack: equals i_vpu_cmd_ack routed to the grantee only.
- o_vpu_cmd_sel  output  1  VPU bus select.
- i_vpu_cmd_ack  input  1  VPU bus ack (command consumed).
- o_vpu_cmd_op  output  5  muxed opcode.
- o_vpu_cmd_th  output  3  muxed thread mask.
- o_vpu_cmd_pl  output  48  muxed payload.
- o_grant  output  NREQ  one-hot current grant (zero when idle).
- o_busy  output  1  high in state GRANT or when any i_req_sel is high.

Behaviour:
- State register: IDLE or GRANT. Registers: grant index gidx, burst counter bcnt (8 bits), round-robin pointer rrp (index after the last grantee).
- Reset (rst high at posedge): state IDLE, o_grant=0, bcnt=0, rrp=0. This applies mid-burst too: the grant is dropped immediately and no ack is routed.
- Output datapath is combinational:
  - o_vpu_cmd_sel = (state==GRANT) && i_req_sel[gidx].
  - op/th/pl = fields of gidx in GRANT, and 0 in IDLE.
  - o_req_ack[gidx] = i_vpu_cmd_ack && o_vpu_cmd_sel. All other acks are 0.
- i_vpu_cmd_ack while o_vpu_cmd_sel is low is ignored.
- Round-robin pick: first k with i_req_sel[k] high, scanning rrp, rrp+1, ... modulo NREQ.
- IDLE: if any sel is high, move to GRANT next cycle with gidx=pick, bcnt=0. Latency is one cycle from request to bus sel.
- GRANT transitions, evaluated each posedge:
  - a) i_req_sel[gidx] low (grantee finished): set rrp=gidx+1 mod NREQ. If another requester is pending, stay in GRANT with gidx=pick (excluding the old grantee) and bcnt=0. Otherwise go to IDLE.
  - b) Ack this cycle and bcnt+1==MAX_BURST and another requester's sel is high: rotate. Set rrp=gidx+1, gidx=pick excluding the old grantee, bcnt=0. The old grantee keeps sel high and simply waits without ack. No command is lost, because its current command was already consumed by this ack.
  - c) Ack this cycle otherwise: bcnt=bcnt+1, saturating at MAX_BURST. If no other request is pending, the grantee continues past the limit.
  - d) Otherwise hold.
- Grant never changes in a cycle where the bus shows sel high without ack, so a command presented to the VPU stays stable until acked.
- Zero-bubble handoff on rotation (b): the new grantee's command appears on the bus in the cycle after the final ack.
- Simultaneous grantee sel drop and new requests: handled by (a) in one cycle.
- A requester raising sel in the same cycle its own ack arrives is legal: its next command.
- NREQ==1 degenerates to pass-through with a one-cycle start latency.

Optional Feature:
- Macro VXE_CU_VPU_ARB_PRIO_EN.
- Defined: requester 0 has absolute priority. Any pick returns 0 whenever i_req_sel[0] is high. Rule (b) rotates to requester 0 at the burst limit regardless of rrp. Requester 0 itself is never rotated away by the burst limit.
- Undefined: pure round-robin as above.

Test Plan:
- Reset then single requester: req1 presents 3 commands (op=1,2,3) with acks each cycle. Required: bus sel rises 1 cycle after req sel; op sequence 1,2,3; o_req_ack[1] only; state returns to IDLE and o_grant=0 one cycle after req1 drops sel.
- Both requesters constantly busy, MAX_BURST=4, ack every cycle. Required: grant alternates 0,1,0,1 every 4 acks; no ack is lost or duplicated; handoff has zero idle cycles.
- Backpressure: ack held low 5 cycles while req0 is granted and req1 is pending. Required: o_vpu_cmd_op/pl stable and grant unchanged during all 5 cycles.
- Grantee drops sel after 2 commands while req1 is pending. Required: req1 is granted the next cycle; bcnt restarts; rrp points after 0.
- rst asserted mid-burst. Required: the next cycle has o_vpu_cmd_sel=0, o_grant=0, all o_req_ack=0. After release, arbitration restarts from requester 0.
- With VXE_CU_VPU_ARB_PRIO_EN, MAX_BURST=2, req1 granted and req0 raising sel. Required: after req1's 2nd ack the grant moves to 0; req0 keeps the bus for 6 back-to-back commands.
